// File: rtl/id_exe_stage.sv
// -----------------------------------------------------------------------------
// id_exe_stage
// ID/EXE pipeline register with load-use hazard detection.
//
// Captures the decoded register addresses, control bits and operands of the
// instruction leaving ID, and presents them to EXE one cycle later. It also
// detects the classic load-use hazard. In that case it requests a one-cycle
// stall of PC and IF/ID, and it injects a bubble into EXE.
//
// Optional feature:
//   LOADUSE_STALL_COUNT_EN -- when defined, stall_count counts inserted
//   load-use bubbles and saturates at all-ones. When undefined, stall_count
//   is tied to 0.
//
// Parameters:
//   DATA_W  width of operand / immediate datapaths
//   CNT_W   width of the stall counter
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   ena                    pipeline enable (0 freezes every register)
//   flush                  squash the instruction entering EXE
//   rs_in, rt_in, rd_in    register addresses from ID
//   regDst_in, memRead_in, memWrite_in, regWrite_in   ID control bits
//   dataA_in, dataB_in, imm_in                        ID operands
//   rs_id, rt_id, rd_id    registered addresses for the forwarding unit
//   regDst, memRead_exe, memWrite_exe, regWrite_exe   registered controls
//   dataA, dataB, imm      registered operands
//   outReg_exe             destination register of the EXE instruction
//   stall                  combinational hold request for PC and IF/ID
//   stall_count            number of load-use bubbles inserted
// -----------------------------------------------------------------------------
module id_exe_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  input  logic              flush,
  input  logic [4:0]        rs_in,
  input  logic [4:0]        rt_in,
  input  logic [4:0]        rd_in,
  input  logic              regDst_in,
  input  logic              memRead_in,
  input  logic              memWrite_in,
  input  logic              regWrite_in,
  input  logic [DATA_W-1:0] dataA_in,
  input  logic [DATA_W-1:0] dataB_in,
  input  logic [DATA_W-1:0] imm_in,
  output logic [4:0]        rs_id,
  output logic [4:0]        rt_id,
  output logic [4:0]        rd_id,
  output logic              regDst,
  output logic              memRead_exe,
  output logic              memWrite_exe,
  output logic              regWrite_exe,
  output logic [DATA_W-1:0] dataA,
  output logic [DATA_W-1:0] dataB,
  output logic [DATA_W-1:0] imm,
  output logic [4:0]        outReg_exe,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  logic hazard;

  // The destination comes only from registered state. A non-writing
  // instruction reports register 0, so it can never match an ID source.
  always_comb begin
    outReg_exe = 5'd0;
    if (regWrite_exe) begin
      outReg_exe = regDst ? rd_id : rt_id;
    end
  end

  // Load in EXE whose result is needed by the instruction in ID. Register 0 is
  // excluded because it is hard-wired and never really written.
  assign hazard = memRead_exe && (outReg_exe != 5'd0) &&
                  ((outReg_exe == rs_in) || (outReg_exe == rt_in));

  // A flush already kills the dependent instruction, so stalling is pointless.
  // A frozen pipeline never stalls.
  assign stall = hazard && ena && !flush;

  // The pipeline register. Reset, flush and stall all load the same bubble.
  // During a stall, the ID instruction is held upstream and is presented
  // again on the next cycle. At that point the bubble has cleared
  // memRead_exe, so the instruction goes through.
  always_ff @(posedge clk) begin
    if (reset || (ena && (flush || stall))) begin
      rs_id        <= 5'd0;
      rt_id        <= 5'd0;
      rd_id        <= 5'd0;
      regDst       <= 1'b0;
      memRead_exe  <= 1'b0;
      memWrite_exe <= 1'b0;
      regWrite_exe <= 1'b0;
      dataA        <= '0;
      dataB        <= '0;
      imm          <= '0;
    end else if (ena) begin
      rs_id        <= rs_in;
      rt_id        <= rt_in;
      rd_id        <= rd_in;
      regDst       <= regDst_in;
      memRead_exe  <= memRead_in;
      memWrite_exe <= memWrite_in;
      regWrite_exe <= regWrite_in;
      dataA        <= dataA_in;
      dataB        <= dataB_in;
      imm          <= imm_in;
    end
  end

`ifdef LOADUSE_STALL_COUNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // The counter saturates instead of wrapping, so a long run never appears
  // to have fewer stalls than a short one.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_id_exe_stage.sv
// -----------------------------------------------------------------------------
// tb_id_exe_stage
// Self-checking bench for id_exe_stage.
//
// Stimulus comes from a table of vectors. Each vector states:
//   - whether stall is expected, and
//   - what EXE should hold after the edge: the loaded inputs, a bubble,
//     the previous contents, or the reset state.
//
// Expected register contents are pushed to a scoreboard queue when a vector
// is driven. They are popped and compared one cycle later.
//
// A short counter width is used so that saturation is reachable quickly.
// Define LOADUSE_STALL_COUNT_EN to exercise the counter.
// -----------------------------------------------------------------------------
module tb_id_exe_stage;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  typedef enum logic [1:0] {ACT_LOAD, ACT_BUBBLE, ACT_HOLD, ACT_RESET} act_e;

  typedef struct {
    logic              rst;
    logic              ena;
    logic              flush;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [3:0]        ctrl;
    logic [DATA_W-1:0] da;
    logic [DATA_W-1:0] db;
    logic [DATA_W-1:0] im;
    logic              exp_stall;
    act_e              act;
  } vec_t;

  // ctrl ordering is {regDst, memRead, memWrite, regWrite}
  typedef struct packed {
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [3:0]        ctrl;
    logic [DATA_W-1:0] da;
    logic [DATA_W-1:0] db;
    logic [DATA_W-1:0] im;
    logic [4:0]        out_reg;
    logic [CNT_W-1:0]  cnt;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset, ena, flush;
  logic [4:0]        rs_in, rt_in, rd_in;
  logic              regDst_in, memRead_in, memWrite_in, regWrite_in;
  logic [DATA_W-1:0] dataA_in, dataB_in, imm_in;
  logic [4:0]        rs_id, rt_id, rd_id;
  logic              regDst, memRead_exe, memWrite_exe, regWrite_exe;
  logic [DATA_W-1:0] dataA, dataB, imm;
  logic [4:0]        outReg_exe;
  logic              stall;
  logic [CNT_W-1:0]  stall_count;

  int     n_checks = 0;
  int     n_fail   = 0;
  exp_t   sb[$];
  exp_t   last_exp;
  logic [CNT_W-1:0] cnt_model;
  vec_t   vecs[$];

  id_exe_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .ena(ena), .flush(flush),
    .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
    .regDst_in(regDst_in), .memRead_in(memRead_in),
    .memWrite_in(memWrite_in), .regWrite_in(regWrite_in),
    .dataA_in(dataA_in), .dataB_in(dataB_in), .imm_in(imm_in),
    .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
    .regDst(regDst), .memRead_exe(memRead_exe),
    .memWrite_exe(memWrite_exe), .regWrite_exe(regWrite_exe),
    .dataA(dataA), .dataB(dataB), .imm(imm),
    .outReg_exe(outReg_exe), .stall(stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Guard against any hang. This stops the run with a FAIL line.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(input logic rst, input logic en, input logic fl,
                                 input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [3:0] ctrl,
                                 input logic [DATA_W-1:0] da,
                                 input logic [DATA_W-1:0] db,
                                 input logic [DATA_W-1:0] im,
                                 input logic st, input act_e act);
    vec_t v;
    v.rst = rst; v.ena = en; v.flush = fl;
    v.rs = rs; v.rt = rt; v.rd = rd; v.ctrl = ctrl;
    v.da = da; v.db = db; v.im = im;
    v.exp_stall = st; v.act = act;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = sb.pop_front();
      cmp("addr", {49'd0, rs_id, rt_id, rd_id}, {49'd0, e.rs, e.rt, e.rd});
      cmp("ctrl", {60'd0, regDst, memRead_exe, memWrite_exe, regWrite_exe},
          {60'd0, e.ctrl});
      cmp("dataA_dataB", {dataA, dataB}, {e.da, e.db});
      cmp("imm_outReg", {27'd0, imm, outReg_exe}, {27'd0, e.im, e.out_reg});
      cmp("stall_count", {{(64-CNT_W){1'b0}}, stall_count},
          {{(64-CNT_W){1'b0}}, e.cnt});
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    reset = v.rst; ena = v.ena; flush = v.flush;
    rs_in = v.rs; rt_in = v.rt; rd_in = v.rd;
    {regDst_in, memRead_in, memWrite_in, regWrite_in} = v.ctrl;
    dataA_in = v.da; dataB_in = v.db; imm_in = v.im;
    #1;
    cmp("stall", {63'd0, stall}, {63'd0, v.exp_stall});
    e = '0;
    case (v.act)
      ACT_LOAD: begin
        e.rs = v.rs; e.rt = v.rt; e.rd = v.rd; e.ctrl = v.ctrl;
        e.da = v.da; e.db = v.db; e.im = v.im;
      end
      ACT_HOLD: e = last_exp;
      default:  e = '0;
    endcase
`ifdef LOADUSE_STALL_COUNT_EN
    if (v.act == ACT_RESET) cnt_model = '0;
    else if (v.exp_stall && (cnt_model != {CNT_W{1'b1}})) cnt_model = cnt_model + 1'b1;
`else
    cnt_model = '0;
`endif
    e.cnt = cnt_model;
    e.out_reg = e.ctrl[0] ? (e.ctrl[3] ? e.rd : e.rt) : 5'd0;
    last_exp = e;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    reset = 1'b1; ena = 1'b0; flush = 1'b0;
    rs_in = '0; rt_in = '0; rd_in = '0;
    {regDst_in, memRead_in, memWrite_in, regWrite_in} = 4'b0000;
    dataA_in = '0; dataB_in = '0; imm_in = '0;
    last_exp = '0;
    cnt_model = '0;
    repeat (2) @(posedge clk);
    #1;

    // rst ena flush  rs  rt  rd  ctrl    dataA      dataB      imm    stall act
    vecs.push_back(mkVec(1, 1, 0,  8,  8,  9, 4'b1111, 'hDEAD,   'hBEEF,   'h1234, 0, ACT_RESET));
    vecs.push_back(mkVec(0, 1, 0,  3,  4,  5, 4'b1001, 'h11,     'h22,     'h33,   0, ACT_LOAD));
    vecs.push_back(mkVec(0, 1, 0,  1,  8,  0, 4'b0101, 'h100,    'h200,    'h4,    0, ACT_LOAD));
    vecs.push_back(mkVec(0, 1, 0,  8,  9, 10, 4'b1001, 'hA,      'hB,      'h0,    1, ACT_BUBBLE));
    vecs.push_back(mkVec(0, 1, 0,  8,  9, 10, 4'b1001, 'hA,      'hB,      'h0,    0, ACT_LOAD));
    vecs.push_back(mkVec(0, 1, 0,  2,  0,  0, 4'b0101, 'h5,      'h6,      'h8,    0, ACT_LOAD));
    vecs.push_back(mkVec(0, 1, 0,  0,  3,  7, 4'b1001, 'h7,      'h9,      'h0,    0, ACT_LOAD));
    vecs.push_back(mkVec(0, 1, 0,  4, 12,  0, 4'b0101, 'hC0,     'hC1,     'h10,   0, ACT_LOAD));
    vecs.push_back(mkVec(0, 1, 1,  6, 12, 11, 4'b1001, 'hF0,     'hF1,     'h0,    0, ACT_BUBBLE));
    vecs.push_back(mkVec(0, 1, 0,  4, 13,  0, 4'b0101, 'hD0,     'hD1,     'h14,   0, ACT_LOAD));
    vecs.push_back(mkVec(0, 0, 0, 13,  1,  2, 4'b1001, 'h1,      'h2,      'h3,    0, ACT_HOLD));
    vecs.push_back(mkVec(0, 0, 0,  5, 13,  3, 4'b1101, 'h4,      'h5,      'h6,    0, ACT_HOLD));
    vecs.push_back(mkVec(0, 0, 1, 13, 13,  4, 4'b0011, 'h7,      'h8,      'h9,    0, ACT_HOLD));
    vecs.push_back(mkVec(0, 1, 0, 13, 14,  0, 4'b0101, 'hE0,     'hE1,     'h18,   1, ACT_BUBBLE));
    vecs.push_back(mkVec(0, 1, 0, 13, 14,  0, 4'b0101, 'hE0,     'hE1,     'h18,   0, ACT_LOAD));
    vecs.push_back(mkVec(0, 1, 0, 14, 15,  0, 4'b0101, 'hE2,     'hE3,     'h1C,   1, ACT_BUBBLE));
    vecs.push_back(mkVec(0, 1, 0, 14, 15,  0, 4'b0101, 'hE2,     'hE3,     'h1C,   0, ACT_LOAD));
    vecs.push_back(mkVec(0, 1, 0,  2, 15,  0, 4'b0010, 'hE4,     'hE5,     'h20,   1, ACT_BUBBLE));
    vecs.push_back(mkVec(0, 1, 0,  2, 15,  0, 4'b0010, 'hE4,     'hE5,     'h20,   0, ACT_LOAD));
    vecs.push_back(mkVec(0, 1, 0,  0,  0, 31, 4'b1001, 'hFFFFFFFF, 'h80000000, 'h7FFFFFFF, 0, ACT_LOAD));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
    end

    // Reset arrives on the very edge where a stall is pending. The stall is
    // dropped, and the re-presented consumer then enters EXE normally.
    applyStimulus(mkVec(0, 1, 0,  1, 20,  0, 4'b0101, 'h1, 'h2, 'h3, 0, ACT_LOAD));
    applyStimulus(mkVec(1, 1, 0, 20, 21, 22, 4'b1001, 'h4, 'h5, 'h6, 1, ACT_RESET));
    applyStimulus(mkVec(0, 1, 0, 20, 21, 22, 4'b1001, 'h4, 'h5, 'h6, 0, ACT_LOAD));

    // Load followed by a dependent consumer, repeated past the counter range.
    for (int k = 0; k < 70; k++) begin
      applyStimulus(mkVec(0, 1, 0, 1, 8,  0, 4'b0101, k, 'h0, 'h0, 0, ACT_LOAD));
      applyStimulus(mkVec(0, 1, 0, 8, 9, 10, 4'b1001, k, 'h1, 'h2, 1, ACT_BUBBLE));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_exe_stage.md
ID_EXE_STAGE -- requirements
Module: id_exe_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of operand/immediate datapaths.
REQ-002 SHALL have parameter CNT_W, default 16, width of stall counter (REQ-026).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-005 ena  input  1  pipeline enable; 0 freezes all registers.
REQ-006 flush  input  1  taken branch/jump; squash instruction entering EXE.
REQ-007 rs_in, rt_in, rd_in  input  5 each  register addresses decoded in ID.
REQ-008 regDst_in, memRead_in, memWrite_in, regWrite_in  input  1 each  ID control bits.
REQ-009 dataA_in, dataB_in, imm_in  input  DATA_W each  register-file reads and sign-extended immediate.
REQ-010 rs_id, rt_id, rd_id  output  5 each  registered addresses for EXE forwarding unit.
REQ-011 regDst, memRead_exe, memWrite_exe, regWrite_exe  output  1 each  registered controls.
REQ-012 dataA, dataB, imm  output  DATA_W each  registered operands.
REQ-013 outReg_exe  output  5  destination of instruction in EXE: rd_id if regDst=1, else rt_id; 0 when regWrite_exe=0.
REQ-014 stall  output  1  combinational; 1 holds PC and IF/ID register.
REQ-015 stall_count  output  CNT_W  number of load-use bubbles inserted.

Function
REQ-016 SHALL register all *_in signals into the corresponding outputs on every rising edge with ena=1, stall=0, flush=0 (latency 1 cycle).
REQ-017 load-use hazard SHALL be: memRead_exe=1 AND outReg_exe!=0 AND (outReg_exe==rs_in OR outReg_exe==rt_in).
REQ-018 stall SHALL equal hazard AND ena AND NOT flush.
REQ-019 On stall=1 edge: SHALL load a bubble (regWrite_exe, memRead_exe, memWrite_exe, regDst = 0; addresses and data = 0); ID inputs are held upstream and re-presented next cycle.
REQ-020 A bubble clears memRead_exe, so a load-use hazard SHALL produce exactly one stall cycle; back-to-back loads with dependent consumer produce one stall per load.
REQ-021 flush=1 with ena=1 SHALL load a bubble regardless of hazard; flush has priority over stall.
REQ-022 ena=0 SHALL hold every register unchanged and force stall=0; flush ignored while ena=0.
REQ-023 Register 0 as destination SHALL never cause a hazard.
REQ-024 outReg_exe SHALL be combinational from registered state only (no input-to-output path except stall).

Reset
REQ-025 reset=1 at an edge SHALL override ena/flush/stall and load the bubble state: all outputs 0, stall_count 0; stall thereby 0 the following cycle; reset mid-stall discards the pending stall.

Configuration
REQ-026 With macro LOADUSE_STALL_COUNT_EN defined: stall_count SHALL increment by 1 on each edge where stall=1, saturating at all-ones; cleared only by reset.
REQ-027 Without LOADUSE_STALL_COUNT_EN: counter not implemented; stall_count SHALL be constant 0; all other behaviour identical.

Verification
REQ-028 Reset: reset=1 one edge with arbitrary inputs -> all outputs 0, stall=0 next cycle.
REQ-029 Pass-through: rs_in=3, rt_in=4, rd_in=5, regDst_in=1, regWrite_in=1, dataA_in=0x11 -> next cycle rs_id=3, rt_id=4, rd_id=5, outReg_exe=5, dataA=0x11, stall=0.
REQ-030 Load-use: EXE holds lw with rt_id=8, regDst=0, memRead_exe=1; ID presents rs_in=8 -> stall=1 one cycle, bubble in EXE (regWrite_exe=0), next cycle stall=0 and instruction enters EXE; stall_count=1 if macro defined.
REQ-031 Zero register: EXE lw with rt_id=0, ID rs_in=0 -> stall=0.
REQ-032 Flush vs stall: hazard as REQ-030 plus flush=1 -> stall=0, bubble loaded, stall_count unchanged.
REQ-033 Freeze: ena=0 for 3 cycles with changing inputs and hazard present -> outputs unchanged, stall=0; saturation: counter at 0xFFFF plus one stall -> remains 0xFFFF.
